// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types for the up/down modulo counter.
//   cnt_mode_t : selects what happens when a step crosses 0 or MAX_COUNT.
//                CNT_WRAP folds the count back into range, modulo MAX_COUNT+1.
//                CNT_SAT  clamps the count at the boundary it crossed.
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_t;

endpackage : counter_pkg

// File: rtl/counter_step_unit.sv
// -----------------------------------------------------------------------------
// counter_step_unit
// Purely combinational next-count arithmetic for counter_updown_mod.
// Produces the count that follows one enabled step, and flags an overflow
// event when the step leaves the range 0..MAX_COUNT.
//
// Ports
//   cnt_i      [WIDTH-1:0]       current count (always within 0..MAX_COUNT)
//   step_i     [STEP_WIDTH-1:0]  unsigned step magnitude
//   up_i                         1 = count up, 0 = count down
//   mode_i     cnt_mode_t        CNT_WRAP or CNT_SAT boundary behaviour
//   cnt_next_o [WIDTH-1:0]       count after the step
//   ovf_o                        step went out of range (either mode)
// -----------------------------------------------------------------------------
module counter_step_unit
    import counter_pkg::*;
#(
    parameter int    WIDTH      = 8,
    parameter longint MAX_COUNT = (longint'(1) << WIDTH) - 1,
    parameter int    STEP_WIDTH = 4
) (
    input  logic [WIDTH-1:0]      cnt_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  logic                  up_i,
    input  cnt_mode_t             mode_i,
    output logic [WIDTH-1:0]      cnt_next_o,
    output logic                  ovf_o
);

    // Wide enough that count + step never truncates before the range check,
    // and wide enough to hold MAX_COUNT+1 even when MAX_COUNT = 2**WIDTH-1.
    localparam int             SW    = WIDTH + STEP_WIDTH + 1;
    localparam logic [SW-1:0]  MAX_S = SW'(MAX_COUNT);
    localparam logic [SW-1:0]  MOD_S = SW'(MAX_COUNT + 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

    // Fold an arbitrary non-negative value into 0..MAX_COUNT.
    function automatic logic [WIDTH-1:0] wrap_mod(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        r = v % MOD_S;
        return WIDTH'(r);
    endfunction

    // Clamp to the boundary that was crossed in the given direction.
    function automatic logic [WIDTH-1:0] sat_bound(input logic up);
        return up ? MAX_W : '0;
    endfunction

    logic [SW-1:0] cnt_ext;
    logic [SW-1:0] step_ext;
    logic [SW-1:0] raw_sum;
    logic [SW-1:0] step_red;
    logic [SW-1:0] raw_diff;

    always_comb begin
        cnt_ext  = SW'(cnt_i);
        step_ext = SW'(step_i);
        raw_sum  = cnt_ext + step_ext;
        // Reducing the step first keeps count + MOD - step non-negative even
        // when the step is larger than the whole counting range.
        step_red = step_ext % MOD_S;
        raw_diff = cnt_ext + MOD_S - step_red;
    end

    always_comb begin
        cnt_next_o = cnt_i;
        ovf_o      = 1'b0;
        if (up_i) begin
            if (raw_sum > MAX_S) begin
                ovf_o      = 1'b1;
                cnt_next_o = (mode_i == CNT_SAT) ? sat_bound(1'b1) : wrap_mod(raw_sum);
            end else begin
                cnt_next_o = WIDTH'(raw_sum);
            end
        end else begin
            if (step_ext > cnt_ext) begin
                ovf_o      = 1'b1;
                cnt_next_o = (mode_i == CNT_SAT) ? sat_bound(1'b0) : wrap_mod(raw_diff);
            end else begin
                cnt_next_o = WIDTH'(cnt_ext - step_ext);
            end
        end
    end

endmodule : counter_step_unit

// File: rtl/counter_updown_mod.sv
// -----------------------------------------------------------------------------
// counter_updown_mod
// Up/down counter over 0..MAX_COUNT with a variable step, wrap or saturate
// boundary handling, and overflow pulse/sticky flags.
// Per-cycle priority: reset > clear > load > enable > hold.
//
// Ports
//   clk         clock, all registers on rising edge
//   reset       synchronous active-high reset
//   clear       count <= 0
//   load        count <= load_data (clamped to MAX_COUNT)
//   load_data   [WIDTH-1:0] value to load
//   enable      advance count by step
//   up_down     1 = up, 0 = down
//   step        [STEP_WIDTH-1:0] unsigned step magnitude
//   mode        cnt_mode_t: CNT_WRAP or CNT_SAT
//   ovf_clr     clear ovf_sticky (an overflow in the same cycle wins)
//   count       [WIDTH-1:0] current count, straight from the register
//   ovf_pulse   registered one-cycle overflow marker, aligned with count
//   ovf_sticky  registered latched overflow flag
//   at_max      count == MAX_COUNT
//   at_zero     count == 0
// -----------------------------------------------------------------------------
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int     WIDTH      = 8,
    parameter longint MAX_COUNT  = (longint'(1) << WIDTH) - 1,
    parameter int     STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic [STEP_WIDTH-1:0] step,
    input  cnt_mode_t             mode,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  ovf_pulse,
    output logic                  ovf_sticky,
    output logic                  at_max,
    output logic                  at_zero
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

    // Loaded values above the terminal count are pinned to it so the count
    // register never leaves 0..MAX_COUNT.
    function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
        return (v > MAX_W) ? MAX_W : v;
    endfunction

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_pulse_q, ovf_pulse_d;
    logic             ovf_sticky_q, ovf_sticky_d;

    logic [WIDTH-1:0] step_next;
    logic             step_ovf;
    logic             step_taken;

    counter_step_unit #(
        .WIDTH      (WIDTH),
        .MAX_COUNT  (MAX_COUNT),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_step (
        .cnt_i      (count_q),
        .step_i     (step),
        .up_i       (up_down),
        .mode_i     (mode),
        .cnt_next_o (step_next),
        .ovf_o      (step_ovf)
    );

    // A step only happens when neither clear nor load claims the cycle, so
    // any overflow it would have raised is discarded along with it.
    assign step_taken = enable && !clear && !load;

    always_comb begin
        count_d      = count_q;
        ovf_pulse_d  = 1'b0;
        ovf_sticky_d = ovf_sticky_q;

        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = sat_load(load_data);
        end else if (enable) begin
            count_d = step_next;
        end

        ovf_pulse_d = step_taken && step_ovf;

        // Setting dominates clearing when both happen together.
        if (ovf_pulse_d) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            ovf_pulse_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            ovf_pulse_q  <= ovf_pulse_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign count      = count_q;
    assign ovf_pulse  = ovf_pulse_q;
    assign ovf_sticky = ovf_sticky_q;
    assign at_max     = (count_q == MAX_W);
    assign at_zero    = (count_q == '0);

endmodule : counter_updown_mod

// File: tb/tb_counter_updown_mod.sv
// -----------------------------------------------------------------------------
// tb_counter_updown_mod
// Self-checking bench for counter_updown_mod (WIDTH=4, MAX_COUNT=9,
// STEP_WIDTH=4). Directed scenarios followed by randomized stimulus, all
// compared against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_counter_updown_mod;
    import counter_pkg::*;

    localparam int WIDTH      = 4;
    localparam int MAXC       = 9;
    localparam int STEP_WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  clear;
    logic                  load;
    logic [WIDTH-1:0]      load_data;
    logic                  enable;
    logic                  up_down;
    logic [STEP_WIDTH-1:0] step;
    cnt_mode_t             mode;
    logic                  ovf_clr;
    logic [WIDTH-1:0]      count;
    logic                  ovf_pulse;
    logic                  ovf_sticky;
    logic                  at_max;
    logic                  at_zero;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int m_cnt    = 0;
    int m_pulse  = 0;
    int m_sticky = 0;

    counter_updown_mod #(
        .WIDTH      (WIDTH),
        .MAX_COUNT  (MAXC),
        .STEP_WIDTH (STEP_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .load       (load),
        .load_data  (load_data),
        .enable     (enable),
        .up_down    (up_down),
        .step       (step),
        .mode       (mode),
        .ovf_clr    (ovf_clr),
        .count      (count),
        .ovf_pulse  (ovf_pulse),
        .ovf_sticky (ovf_sticky),
        .at_max     (at_max),
        .at_zero    (at_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Next state of the model from the inputs currently being driven.
    task automatic model_update();
        int nc;
        int evt;
        int s;
        int d;
        if (reset) begin
            m_cnt = 0; m_pulse = 0; m_sticky = 0;
        end else begin
            nc  = m_cnt;
            evt = 0;
            if (clear) begin
                nc = 0;
            end else if (load) begin
                nc = (int'(load_data) > MAXC) ? MAXC : int'(load_data);
            end else if (enable) begin
                if (up_down) begin
                    s = m_cnt + int'(step);
                    if (s > MAXC) begin
                        evt = 1;
                        nc  = (mode == CNT_WRAP) ? s % (MAXC + 1) : MAXC;
                    end else begin
                        nc = s;
                    end
                end else begin
                    d = m_cnt - int'(step);
                    if (d < 0) begin
                        evt = 1;
                        nc  = (mode == CNT_WRAP) ? ((d % (MAXC + 1)) + MAXC + 1) % (MAXC + 1) : 0;
                    end else begin
                        nc = d;
                    end
                end
            end
            m_pulse = evt;
            if (evt != 0) m_sticky = 1;
            else if (ovf_clr) m_sticky = 0;
            m_cnt = nc;
        end
    endtask

    // One clock: update model, take the edge, compare all outputs.
    task automatic cycle(input string tag);
        model_update();
        @(posedge clk);
        #1;
        chk({tag, ".count"},  int'(count),      m_cnt);
        chk({tag, ".pulse"},  int'(ovf_pulse),  m_pulse);
        chk({tag, ".sticky"}, int'(ovf_sticky), m_sticky);
        chk({tag, ".at_max"}, int'(at_max),     (m_cnt == MAXC) ? 1 : 0);
        chk({tag, ".at_zero"},int'(at_zero),    (m_cnt == 0) ? 1 : 0);
    endtask

    task automatic idle();
        reset = 0; clear = 0; load = 0; load_data = '0; enable = 0;
        up_down = 1; step = '0; mode = CNT_WRAP; ovf_clr = 0;
    endtask

    task automatic do_load(input int v);
        idle();
        load = 1; load_data = WIDTH'(v);
        cycle("load");
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        // Model starts unknown-free at 0; reset establishes it in the DUT.
        cycle("rst0");
        cycle("rst1");
        chk("rst.count", int'(count), 0);
        chk("rst.at_zero", int'(at_zero), 1);
        chk("rst.at_max", int'(at_max), 0);

        // Reset beats enable with count=7
        do_load(7);
        reset = 1; enable = 1; up_down = 1; step = 4'd3;
        cycle("rst_mid");
        chk("rst_mid.count", int'(count), 0);
        chk("rst_mid.pulse", int'(ovf_pulse), 0);
        chk("rst_mid.sticky", int'(ovf_sticky), 0);

        // Wrap up: 8 + 3 -> 1 with overflow
        do_load(8);
        mode = CNT_WRAP; up_down = 1; step = 4'd3; enable = 1;
        cycle("wrap_up");
        chk("wrap_up.count", int'(count), 1);
        chk("wrap_up.pulse", int'(ovf_pulse), 1);
        chk("wrap_up.sticky", int'(ovf_sticky), 1);
        idle();
        cycle("wrap_up_after");
        chk("wrap_up_after.pulse", int'(ovf_pulse), 0);
        chk("wrap_up_after.sticky", int'(ovf_sticky), 1);

        // Saturating down: 2 - 5 -> 0, repeated pulses while held
        do_load(2);
        ovf_clr = 1;
        cycle("clr_sticky");
        idle();
        mode = CNT_SAT; up_down = 0; step = 4'd5; enable = 1;
        cycle("sat_dn0");
        chk("sat_dn0.count", int'(count), 0);
        chk("sat_dn0.pulse", int'(ovf_pulse), 1);
        cycle("sat_dn1");
        chk("sat_dn1.count", int'(count), 0);
        chk("sat_dn1.pulse", int'(ovf_pulse), 1);
        cycle("sat_dn2");
        chk("sat_dn2.pulse", int'(ovf_pulse), 1);

        // Load with enable, clamped; then clear beats load
        idle();
        load = 1; load_data = 4'd14; enable = 1; up_down = 1; step = 4'd5;
        cycle("ld_en");
        chk("ld_en.count", int'(count), 9);
        chk("ld_en.pulse", int'(ovf_pulse), 0);
        clear = 1;
        cycle("clr_ld");
        chk("clr_ld.count", int'(count), 0);

        // Sticky set and clear in the same cycle stays set
        do_load(8);
        mode = CNT_WRAP; up_down = 1; step = 4'd3; enable = 1; ovf_clr = 1;
        cycle("set_clr");
        chk("set_clr.sticky", int'(ovf_sticky), 1);
        idle();
        ovf_clr = 1;
        cycle("clr_only");
        chk("clr_only.sticky", int'(ovf_sticky), 0);

        // step = 0 at the top: hold, no overflow
        do_load(9);
        mode = CNT_WRAP; up_down = 1; step = 4'd0; enable = 1;
        cycle("step0");
        chk("step0.count", int'(count), 9);
        chk("step0.pulse", int'(ovf_pulse), 0);
        chk("step0.at_max", int'(at_max), 1);

        // Wrap with a step larger than the range: 9 + 15 = 24 -> 4; 4 - 15 -> 9
        step = 4'd15;
        cycle("big_up");
        chk("big_up.count", int'(count), 4);
        up_down = 0;
        cycle("big_dn");
        chk("big_dn.count", int'(count), 9);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(0, 31) == 0);
            clear     = ($urandom_range(0, 15) == 0);
            load      = ($urandom_range(0, 7) == 0);
            load_data = WIDTH'($urandom_range(0, 15));
            enable    = ($urandom_range(0, 3) != 0);
            up_down   = 1'($urandom_range(0, 1));
            step      = STEP_WIDTH'($urandom_range(0, 15));
            mode      = cnt_mode_t'($urandom_range(0, 1));
            ovf_clr   = ($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_counter_updown_mod
